// File: rtl/riscvy_pkg.sv
// Shared fetch-side types and constants for the instruction fetch queue.
package riscvy_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small register-based FIFO with a synchronous clear and a combinational head read.
module ifq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches, tags them with their address,
// and buffers returning words for decode, with flush-based redirect.
module ifetch_queue
  import riscvy_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] PC_ex,
  output logic            err_rsp
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   q_cnt;
  logic [CW-1:0]   tag_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_head;
  ifq_entry_t      q_in;
  ifq_entry_t      q_head;
  logic            hs;
  logic            rsp_ok;
  logic            q_push;
  logic            q_pop;

  // Handshake, credit and queue control; tag FIFO occupancy is the outstanding count.
  always_comb begin
    credit         = {1'b0, q_cnt} + {1'b0, tag_cnt};
    rsp_ok         = imem_rsp_valid && (tag_cnt != '0);
    imem_req_valid = reset && !flush && (credit < (CW+1)'(DEPTH));
    hs             = imem_req_valid && imem_req_ready;
    q_push         = rsp_ok && !flush && (drop_cnt == '0);
    q_pop          = inst_valid && !stall && !flush;
    q_in.inst      = imem_rsp_data;
    q_in.pc        = tag_head;
  end

  // Fetch PC, stale-response drop counter and sticky protocol error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC & ~64'h3;
      drop_cnt <= '0;
      err_rsp  <= 1'b0;
    end else begin
      if (flush) begin
        fetch_pc <= PC_ex & ~64'h3;
        drop_cnt <= tag_cnt - CW'(rsp_ok);
      end else begin
        if (hs) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (rsp_ok && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
      if (imem_rsp_valid && (tag_cnt == '0)) begin
        err_rsp <= 1'b1;
      end
    end
  end

  // Stale responses still pop their tag so credit is returned.
  ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (hs),
    .push_data (fetch_pc),
    .pop       (rsp_ok),
    .head      (tag_head),
    .count     (tag_cnt)
  );

  ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_cnt)
  );

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (q_cnt != '0);
  assign inst          = inst_valid ? q_head.inst : NOP_INST;
  assign pc            = inst_valid ? q_head.pc : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model plus a queue-based reference of the fetch queue.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_valid;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] pc_ex = '0;
  logic        err_rsp;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .inst           (inst),
    .pc             (pc),
    .inst_valid     (inst_valid),
    .stall          (stall),
    .flush          (flush),
    .PC_ex          (pc_ex),
    .err_rsp        (err_rsp)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          h0;
  int          lat = 1;
  logic        hold = 1'b0;
  logic        spur = 1'b0;
  logic [63:0] last_hs_addr = '0;

  // memory side: requests seen on the bus, answered in order
  logic [63:0] paddr[$];
  int          pdue[$];

  // reference: delivered-queue of pcs, outstanding tags, drop count, fetch pc, error flag
  logic [63:0] mq[$];
  logic [63:0] tags[$];
  int          mdrop = 0;
  logic [63:0] mpc = '0;
  logic        merr = 1'b0;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, compare outputs, advance memory and reference, cross the edge.
  task automatic step();
    logic        exp_rv;
    logic        rv_ok;
    logic [63:0] a;
    if (spur) begin
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD_BEEF;
    end else if (!hold && paddr.size() > 0 && pdue[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = word(paddr[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    chk("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
    chk("inst", 64'(inst), (mq.size() != 0) ? 64'(word(mq[0])) : 64'(NOP));
    chk("pc", pc, (mq.size() != 0) ? mq[0] : 64'h0);
    exp_rv = !flush && (mq.size() + tags.size() < int'(DEPTH));
    chk("req_valid", 64'(req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", req_addr, mpc);
    chk("err_rsp", 64'(err_rsp), 64'(merr));

    if (req_valid && ready) begin
      paddr.push_back(req_addr);
      pdue.push_back(cyc + lat);
      hs_count++;
      last_hs_addr = req_addr;
    end
    if (rsp_valid && !spur && paddr.size() > 0) begin
      void'(paddr.pop_front());
      void'(pdue.pop_front());
    end

    rv_ok = rsp_valid && (tags.size() > 0);
    if (rsp_valid && tags.size() == 0) merr = 1'b1;
    if (flush) begin
      mq.delete();
      mdrop = tags.size() - (rv_ok ? 1 : 0);
      if (rv_ok) void'(tags.pop_front());
      mpc = pc_ex & ~64'h3;
    end else begin
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (rv_ok) begin
        a = tags.pop_front();
        if (mdrop > 0) mdrop--;
        else mq.push_back(a);
      end
      if (exp_rv && ready) begin
        tags.push_back(mpc);
        mpc = mpc + 64'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset between clock edges, check it takes effect at once and holds across edges.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    ready = 1'b0;
    spur  = 1'b0;
    hold  = 1'b0;
    rsp_valid = 1'b0;
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_inst", 64'(inst), 64'(NOP));
    chk("rst_pc", pc, 64'h0);
    chk("rst_req_valid", 64'(req_valid), 64'h0);
    chk("rst_err", 64'(err_rsp), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(inst_valid), 64'h0);
    chk("rst_hold_req", 64'(req_valid), 64'h0);
    paddr.delete();
    pdue.delete();
    mq.delete();
    tags.delete();
    mdrop = 0;
    mpc   = RESET_PC & ~64'h3;
    merr  = 1'b0;
    lat   = 1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // streaming with ready high and 1-cycle latency
    ready = 1'b1;
    repeat (8) step();

    // stall window: only DEPTH requests fit
    do_reset();
    ready = 1'b1;
    stall = 1'b1;
    h0 = hs_count;
    repeat (10) step();
    chk("stall_reqs", 64'(hs_count - h0), 64'd4);
    chk("stall_valid", 64'(inst_valid), 64'h1);
    chk("stall_pc", pc, 64'h0);
    stall = 1'b0;
    step();
    chk("release_pc", pc, 64'h4);

    // flush with three fetches in flight
    do_reset();
    ready = 1'b1;
    hold  = 1'b1;
    h0 = hs_count;
    repeat (3) step();
    chk("inflight_reqs", 64'(hs_count - h0), 64'd3);
    flush = 1'b1;
    pc_ex = 64'h100;
    step();
    flush = 1'b0;
    hold  = 1'b0;
    step();
    chk("redirect_addr", last_hs_addr, 64'h100);
    for (int i = 0; i < 20 && !inst_valid; i++) step();
    chk("first_valid", 64'(inst_valid), 64'h1);
    chk("first_pc", pc, 64'h100);

    // ready held low: address stable, handshake when ready rises
    do_reset();
    h0 = hs_count;
    repeat (5) step();
    chk("noready_hs", 64'(hs_count - h0), 64'h0);
    chk("noready_addr", req_addr, 64'h0);
    ready = 1'b1;
    step();
    chk("ready_hs", 64'(hs_count - h0), 64'h1);
    chk("ready_addr", last_hs_addr, 64'h0);

    // flush, response and pop in the same cycle
    do_reset();
    ready = 1'b1;
    repeat (3) step();
    chk("pre_flush_valid", 64'(inst_valid), 64'h1);
    flush = 1'b1;
    pc_ex = 64'h203;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(inst_valid), 64'h0);
    chk("flush_err", 64'(err_rsp), 64'h0);
    repeat (6) step();

    // asynchronous reset mid-stream, then refetch from RESET_PC
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 40 && mpc != 64'h40; i++) step();
    chk("reached_40", req_addr, 64'h40);
    do_reset();
    ready = 1'b1;
    step();
    chk("restart_addr", last_hs_addr, RESET_PC);
    repeat (4) step();

    // fetch PC wrap-around at the top of the address space
    flush = 1'b1;
    pc_ex = '1;
    step();
    flush = 1'b0;
    repeat (10) step();

    // randomized traffic
    repeat (2000) begin
      ready = ($urandom % 4) != 0;
      stall = ($urandom % 3) == 0;
      flush = ($urandom % 30) == 0;
      pc_ex = {$urandom, $urandom};
      hold  = ($urandom % 3) == 0;
      lat   = 1 + int'($urandom % 3);
      step();
    end
    flush = 1'b0;
    stall = 1'b0;
    hold  = 1'b0;

    // response with nothing outstanding sets the sticky error
    do_reset();
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("err_sticky", 64'(err_rsp), 64'h1);
    chk("spur_no_push", 64'(inst_valid), 64'h0);
    ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
